// File: rtl/pc_unit_if.sv
// Bus between the PC stage and its surroundings: stall, branch/jump control in, PC values out.
// The control side uses the master modport. The pc_unit uses the slave modport.
interface pc_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                BUSYWAIT;
    logic                BRANCH;
    logic                ZERO;
    logic                JUMP;
    logic [7:0]          OFFSET;
    logic [PC_WIDTH-1:0] PC;
    logic [PC_WIDTH-1:0] PC_PLUS4;
    logic                REDIRECT_PENDING;

    modport master (
        output BUSYWAIT, BRANCH, ZERO, JUMP, OFFSET,
        input  PC, PC_PLUS4, REDIRECT_PENDING
    );

    modport slave (
        input  BUSYWAIT, BRANCH, ZERO, JUMP, OFFSET,
        output PC, PC_PLUS4, REDIRECT_PENDING
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection. It holds the PC during memory stalls.
// A branch or jump taken during a stall is latched and applied when the stall ends.
module pc_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic    CLK,
    input  logic    RESET,
    pc_unit_if.slave bus
);
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pending;
    logic                r_redirect_pending;
    logic [1:0]          r_state;

    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_offset_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_take;

    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_pending_next;
    logic                w_redirect_pending_next;
    logic [1:0]          w_state_next;

    assign w_pc_plus4   = r_pc + PC_WIDTH'(4);
    assign w_offset_ext = {{(PC_WIDTH-8){bus.OFFSET[7]}}, bus.OFFSET};
    // The offset counts words, so it is scaled by 4 with a shift.
    assign w_target     = w_pc_plus4 + {w_offset_ext[PC_WIDTH-3:0], 2'b00};
    assign w_take       = bus.JUMP | (bus.BRANCH & bus.ZERO);

    always_comb begin
        w_pc_next               = r_pc;
        w_pending_next          = r_pending;
        w_redirect_pending_next = r_redirect_pending;
        w_state_next            = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (!bus.BUSYWAIT) begin
                    w_pc_next = w_take ? w_target : w_pc_plus4;
                end else if (w_take) begin
                    w_pending_next          = w_target;
                    w_redirect_pending_next = 1'b1;
                    w_state_next            = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The latched target wins over whatever take/TARGET shows now.
                if (!bus.BUSYWAIT) begin
                    w_pc_next               = r_pending;
                    w_redirect_pending_next = 1'b0;
                    w_state_next            = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pc               <= RESET_VECTOR;
            r_pending          <= '0;
            r_redirect_pending <= 1'b0;
            r_state            <= ST_BOOT;
        end else begin
            r_pc               <= w_pc_next;
            r_pending          <= w_pending_next;
            r_redirect_pending <= w_redirect_pending_next;
            r_state            <= w_state_next;
        end
    end

    assign bus.PC               = r_pc;
    assign bus.PC_PLUS4         = w_pc_plus4;
    assign bus.REDIRECT_PENDING = r_redirect_pending;
endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit. Each vector has an expected value worked out by hand.
// All comparisons go through check_val.
`timescale 1ns/1ps
module tb_pc_unit;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    pc_unit_if #(.PC_WIDTH(32)) bus_if ();

    pc_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_ctl(input logic bw, input logic br, input logic z, input logic j, input logic [7:0] off);
        bus_if.BUSYWAIT = bw;
        bus_if.BRANCH   = br;
        bus_if.ZERO     = z;
        bus_if.JUMP     = j;
        bus_if.OFFSET   = off;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b0;
        set_ctl(0, 0, 0, 0, 8'h00);
        #3;
        check_val("reset_pc", bus_if.PC, 32'h0);
        check_val("reset_rp", 32'(bus_if.REDIRECT_PENDING), 32'h0);
        tick();
        tick();
        check_val("reset_held_pc", bus_if.PC, 32'h0);
        RESET = 1'b1;
        tick();
        check_val("boot_pc", bus_if.PC, 32'h0);
        check_val("boot_plus4", bus_if.PC_PLUS4, 32'h4);
        tick(); check_val("seq_pc4", bus_if.PC, 32'h4);
        tick(); check_val("seq_pc8", bus_if.PC, 32'h8);
        tick(); check_val("seq_pc12", bus_if.PC, 32'hC);
        tick(); check_val("seq_pc16", bus_if.PC, 32'h10);

        // Branch taken, jump backwards, then a branch that is not taken
        set_ctl(0, 1, 1, 0, 8'h03); tick(); check_val("beq_taken", bus_if.PC, 32'h20);
        set_ctl(0, 0, 0, 1, 8'hFE); tick(); check_val("jump_back", bus_if.PC, 32'h1C);
        set_ctl(0, 0, 0, 1, 8'hFC); tick(); check_val("jump_to_10", bus_if.PC, 32'h10);
        set_ctl(0, 1, 0, 0, 8'h03); tick(); check_val("beq_not_taken", bus_if.PC, 32'h14);
        set_ctl(0, 0, 0, 1, 8'hFF); tick(); check_val("jump_self", bus_if.PC, 32'h14);
        set_ctl(0, 0, 0, 1, 8'hFC); tick(); check_val("jump_to_08", bus_if.PC, 32'h08);

        // Stall without take
        set_ctl(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("stall_pc_%0d", i), bus_if.PC, 32'h08);
            check_val($sformatf("stall_rp_%0d", i), 32'(bus_if.REDIRECT_PENDING), 32'h0);
        end
        set_ctl(0, 0, 0, 0, 8'h00); tick(); check_val("stall_release", bus_if.PC, 32'h0C);

        // Redirect during a stall. The first captured target wins.
        set_ctl(0, 0, 0, 1, 8'h08); tick(); check_val("jump_to_30", bus_if.PC, 32'h30);
        set_ctl(1, 0, 0, 1, 8'h04); tick();
        check_val("hold_pc_a", bus_if.PC, 32'h30);
        check_val("hold_rp_a", 32'(bus_if.REDIRECT_PENDING), 32'h1);
        set_ctl(1, 0, 0, 1, 8'h10); tick();
        check_val("hold_pc_b", bus_if.PC, 32'h30);
        check_val("hold_rp_b", 32'(bus_if.REDIRECT_PENDING), 32'h1);
        set_ctl(0, 0, 0, 1, 8'h10); tick();
        check_val("pending_applied", bus_if.PC, 32'h44);
        check_val("pending_cleared", 32'(bus_if.REDIRECT_PENDING), 32'h0);

        // Asynchronous reset while in HOLD
        set_ctl(1, 0, 0, 1, 8'hFF); tick();
        check_val("hold2_rp", 32'(bus_if.REDIRECT_PENDING), 32'h1);
        check_val("hold2_pc", bus_if.PC, 32'h44);
        #1 RESET = 1'b0;
        #1;
        check_val("async_rst_pc", bus_if.PC, 32'h0);
        check_val("async_rst_rp", 32'(bus_if.REDIRECT_PENDING), 32'h0);
        set_ctl(0, 0, 0, 0, 8'h00);
        tick();
        RESET = 1'b1;
        tick(); check_val("reboot_pc", bus_if.PC, 32'h0);
        tick(); check_val("reboot_next", bus_if.PC, 32'h4);

        // Wrap-around through a negative branch target, then a sequential wrap
        set_ctl(0, 0, 0, 1, 8'hFE); tick(); check_val("jump_to_0", bus_if.PC, 32'h0);
        set_ctl(0, 0, 0, 1, 8'hFE); tick();
        check_val("wrap_target", bus_if.PC, 32'hFFFF_FFFC);
        check_val("wrap_plus4", bus_if.PC_PLUS4, 32'h0);
        set_ctl(0, 0, 0, 0, 8'h00); tick(); check_val("wrap_seq", bus_if.PC, 32'h0);

        // JUMP and BRANCH together, with ZERO low, still take the target
        set_ctl(0, 1, 0, 1, 8'h03); tick(); check_val("jump_and_branch", bus_if.PC, 32'h10);
        set_ctl(0, 0, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
